// File: rtl/accel_spi_reader_pkg.sv
// Shared constants, FSM encoding and the tilt deadband rule for the ADXL362 reader.
package accel_spi_reader_pkg;

  localparam logic [7:0] CMD_WRITE     = 8'h0A;
  localparam logic [7:0] CMD_READ      = 8'h0B;
  localparam logic [7:0] REG_POWER_CTL = 8'h2D;
  localparam logic [7:0] REG_XDATA_L   = 8'h0E;
  localparam logic [7:0] PWR_MEASURE   = 8'h02;

  localparam int unsigned INIT_LAST_BYTE = 2;
  localparam int unsigned READ_LAST_BYTE = 5;

  typedef enum logic [2:0] {
    ST_WAIT_PWR,
    ST_INIT,
    ST_READ,
    ST_UPDATE,
    ST_CS_HOLD,
    ST_CS_GAP,
    ST_IDLE
  } state_t;

  // Returns {inc, dec}: assert strictly beyond the deadband, release only below deadband-hysteresis.
  function automatic logic [1:0] tilt_next(input logic signed [11:0] v, input logic inc,
                                           input logic dec, input int deadband,
                                           input int hysteresis);
    int   value;
    int   release_lvl;
    logic n_inc;
    logic n_dec;
    value       = int'(v);
    release_lvl = deadband - hysteresis;
    n_inc = (value > deadband) || (inc && (value >= release_lvl));
    n_dec = (value < -deadband) || (dec && (value <= -release_lvl));
    if (n_inc && n_dec) begin
      n_inc = (value >= 0);
      n_dec = (value < 0);
    end
    return {n_inc, n_dec};
  endfunction

endpackage

// File: rtl/accel_spi_reader_spi_byte_xfer.sv
// Mode-0 SPI byte engine: MSB first, MOSI shifts on SCLK fall, MISO sampled on SCLK rise.
module accel_spi_reader_spi_byte_xfer #(
  parameter int HALF_TOP = 49
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] tx_byte,
  input  logic       miso,
  output logic       busy,
  output logic       done,
  output logic [7:0] rx_byte,
  output logic       sclk,
  output logic       mosi
);

  localparam logic [15:0] HALF_TOP_W = 16'(HALF_TOP);

  logic [15:0] timer;
  logic [3:0]  half_idx;
  logic [6:0]  tx_sr;
  logic [7:0]  rx_sr;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      busy     <= '0;
      done     <= '0;
      sclk     <= '0;
      mosi     <= '0;
      timer    <= '0;
      half_idx <= '0;
      tx_sr    <= '0;
      rx_sr    <= '0;
    end else begin
      done <= 1'b0;
      if (!busy) begin
        if (start) begin
          busy     <= 1'b1;
          mosi     <= tx_byte[7];
          tx_sr    <= tx_byte[6:0];
          timer    <= '0;
          half_idx <= '0;
        end
      end else if (timer == HALF_TOP_W) begin
        timer    <= '0;
        sclk     <= ~sclk;
        half_idx <= half_idx + 4'd1;
        if (!sclk) begin
          rx_sr <= {rx_sr[6:0], miso};
        end else if (half_idx == 4'd15) begin
          // Sixteenth half-period ends on the last falling edge: byte complete.
          busy <= 1'b0;
          done <= 1'b1;
        end else begin
          mosi  <= tx_sr[6];
          tx_sr <= {tx_sr[5:0], 1'b0};
        end
      end else begin
        timer <= timer + 16'd1;
      end
    end
  end

  assign rx_byte = rx_sr;

endmodule

// File: rtl/accel_spi_reader.sv
// ADXL362 poller: enables measurement once, then reads X/Y each tick and derives tilt commands.
module accel_spi_reader
  import accel_spi_reader_pkg::*;
#(
  parameter int CLK_FREQUENCY_HZ       = 100000000,
  parameter int SCLK_FREQUENCY_HZ      = 1000000,
  parameter int UPDATE_FREQUENCY_HZ    = 30,
  parameter int DEADBAND               = 100,
  parameter int HYSTERESIS             = 16,
  parameter int SIMULATE               = 0,
  parameter int SIMULATE_FREQUENCY_CNT = 5
) (
  input  logic        clk,
  input  logic        reset,
  output logic        spi_sclk,
  output logic        spi_mosi,
  input  logic        spi_miso,
  output logic        spi_cs_n,
  output logic        x_increment,
  output logic        x_decrement,
  output logic        y_increment,
  output logic        y_decrement,
  output logic [11:0] x_accel,
  output logic [11:0] y_accel,
  output logic        sample_valid,
  output logic        init_done
);

  localparam int HALF_TOP = (SIMULATE != 0) ? 1 : CLK_FREQUENCY_HZ / (2 * SCLK_FREQUENCY_HZ) - 1;
  localparam int TICK_TOP = (SIMULATE != 0) ? SIMULATE_FREQUENCY_CNT
                                            : CLK_FREQUENCY_HZ / UPDATE_FREQUENCY_HZ - 1;
  localparam logic [15:0] HALF_TOP_W = 16'(HALF_TOP);
  localparam logic [15:0] GAP_TOP_W  = 16'(2 * HALF_TOP + 1);

  state_t      state, state_next;
  logic [31:0] tick_cnt;
  logic        tick;
  logic        pending;
  logic [15:0] timer;
  logic        setup_done;
  logic [2:0]  byte_idx;
  logic [2:0]  last_byte;
  logic        xfer_start;
  logic [7:0]  tx_byte;
  logic        xfer_busy;
  logic        xfer_done;
  logic [7:0]  rx_byte;
  logic [7:0]  xl;
  logic [3:0]  xh_nib;
  logic [7:0]  yl;
  logic [11:0] x_new;
  logic [11:0] y_new;
  logic [1:0]  x_cmd;
  logic [1:0]  y_cmd;

  assign tick = (tick_cnt == 32'(TICK_TOP));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) tick_cnt <= '0;
    else if (tick) tick_cnt <= '0;
    else tick_cnt <= tick_cnt + 32'd1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ST_WAIT_PWR;
    else state <= state_next;
  end

  always_comb begin
    state_next = state;
    xfer_start = 1'b0;
    tx_byte    = 8'h00;
    last_byte  = (state == ST_INIT) ? 3'(INIT_LAST_BYTE) : 3'(READ_LAST_BYTE);
    if (state == ST_INIT) begin
      case (byte_idx)
        3'd0:    tx_byte = CMD_WRITE;
        3'd1:    tx_byte = REG_POWER_CTL;
        default: tx_byte = PWR_MEASURE;
      endcase
    end else begin
      case (byte_idx)
        3'd0:    tx_byte = CMD_READ;
        3'd1:    tx_byte = REG_XDATA_L;
        default: tx_byte = 8'h00;
      endcase
    end
    case (state)
      ST_WAIT_PWR: if (tick) state_next = ST_INIT;
      ST_INIT, ST_READ: begin
        // The done cycle is excluded so byte_idx has advanced before the next start.
        if (setup_done && !xfer_busy && !xfer_done) xfer_start = 1'b1;
        if (xfer_done && (byte_idx == last_byte))
          state_next = (state == ST_INIT) ? ST_CS_HOLD : ST_UPDATE;
      end
      ST_UPDATE:  state_next = ST_CS_HOLD;
      ST_CS_HOLD: if (timer == HALF_TOP_W) state_next = ST_CS_GAP;
      ST_CS_GAP:  if (timer == GAP_TOP_W) state_next = ST_IDLE;
      ST_IDLE:    if (tick || pending) state_next = ST_READ;
      default:    state_next = ST_WAIT_PWR;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      timer      <= '0;
      setup_done <= '0;
      byte_idx   <= '0;
      pending    <= '0;
      spi_cs_n   <= '1;
      init_done  <= '0;
    end else begin
      if (state_next != state) timer <= '0;
      else if ((((state == ST_INIT) || (state == ST_READ)) && !setup_done) ||
               (state == ST_CS_HOLD) || (state == ST_CS_GAP))
        timer <= timer + 16'd1;

      if (state_next != state) setup_done <= 1'b0;
      else if (((state == ST_INIT) || (state == ST_READ)) && (timer == HALF_TOP_W))
        setup_done <= 1'b1;

      if (state_next != state) byte_idx <= '0;
      else if (xfer_done) byte_idx <= byte_idx + 3'd1;

      if (state == ST_IDLE) pending <= 1'b0;
      else if (tick && (state != ST_WAIT_PWR)) pending <= 1'b1;

      spi_cs_n <= !((state_next == ST_INIT) || (state_next == ST_READ) ||
                    (state_next == ST_UPDATE) || (state_next == ST_CS_HOLD));

      // The first frame after reset is always the POWER_CTL write.
      if ((state == ST_CS_HOLD) && (state_next == ST_CS_GAP)) init_done <= 1'b1;
    end
  end

  assign x_new = {xh_nib, xl};
  assign y_new = {rx_byte[3:0], yl};
  assign x_cmd = tilt_next(x_new, x_increment, x_decrement, DEADBAND, HYSTERESIS);
  assign y_cmd = tilt_next(y_new, y_increment, y_decrement, DEADBAND, HYSTERESIS);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      xl           <= '0;
      xh_nib       <= '0;
      yl           <= '0;
      x_accel      <= '0;
      y_accel      <= '0;
      x_increment  <= '0;
      x_decrement  <= '0;
      y_increment  <= '0;
      y_decrement  <= '0;
      sample_valid <= '0;
    end else begin
      sample_valid <= 1'b0;
      if ((state == ST_READ) && xfer_done) begin
        case (byte_idx)
          3'd2: xl     <= rx_byte;
          3'd3: xh_nib <= rx_byte[3:0];
          3'd4: yl     <= rx_byte;
          3'd5: begin
            x_accel                    <= x_new;
            y_accel                    <= y_new;
            {x_increment, x_decrement} <= x_cmd;
            {y_increment, y_decrement} <= y_cmd;
            sample_valid               <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  accel_spi_reader_spi_byte_xfer #(
    .HALF_TOP(HALF_TOP)
  ) u_spi_byte_xfer (
    .clk    (clk),
    .reset  (reset),
    .start  (xfer_start),
    .tx_byte(tx_byte),
    .miso   (spi_miso),
    .busy   (xfer_busy),
    .done   (xfer_done),
    .rx_byte(rx_byte),
    .sclk   (spi_sclk),
    .mosi   (spi_mosi)
  );

endmodule

// File: tb/tb_accel_spi_reader.sv
// Bench for accel_spi_reader with an ADXL362 slave model on the SPI pins.
module tb_accel_spi_reader;

  localparam int DB = 100;
  localparam int HY = 16;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        spi_sclk, spi_mosi, spi_cs_n;
  logic        spi_miso = 1'b0;
  logic        x_increment, x_decrement, y_increment, y_decrement;
  logic [11:0] x_accel, y_accel;
  logic        sample_valid, init_done;

  always #5 clk = ~clk;

  accel_spi_reader #(
    .CLK_FREQUENCY_HZ      (100000000),
    .SCLK_FREQUENCY_HZ     (1000000),
    .UPDATE_FREQUENCY_HZ   (30),
    .DEADBAND              (DB),
    .HYSTERESIS            (HY),
    .SIMULATE              (1),
    .SIMULATE_FREQUENCY_CNT(5)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .spi_sclk    (spi_sclk),
    .spi_mosi    (spi_mosi),
    .spi_miso    (spi_miso),
    .spi_cs_n    (spi_cs_n),
    .x_increment (x_increment),
    .x_decrement (x_decrement),
    .y_increment (y_increment),
    .y_decrement (y_decrement),
    .x_accel     (x_accel),
    .y_accel     (y_accel),
    .sample_valid(sample_valid),
    .init_done   (init_done)
  );

  // Slave: latches the bench's X/Y at cs_n fall and serves them after the two command bytes.
  int          slave_x = 0;
  int          slave_y = 0;
  logic [11:0] xv, yv;
  logic [47:0] slv_tx = '0;
  logic [47:0] slv_rx = '0;
  logic [47:0] last_mosi = '0;
  int          rises = 0;
  int          last_rises = 0;
  int          frames_done = 0;
  logic        prev_cs = 1'b1;
  logic        prev_sclk = 1'b0;

  always @(posedge clk) begin
    if (prev_cs && !spi_cs_n) begin
      xv = 12'(slave_x);
      yv = 12'(slave_y);
      slv_tx = {16'h0000, xv[7:0], {4{xv[11]}}, xv[11:8], yv[7:0], {4{yv[11]}}, yv[11:8]};
      spi_miso <= slv_tx[47];
      slv_rx = '0;
      rises = 0;
    end else if (!prev_cs && spi_cs_n) begin
      last_mosi = slv_rx;
      last_rises = rises;
      frames_done = frames_done + 1;
    end else if (!spi_cs_n) begin
      if (!prev_sclk && spi_sclk) begin
        slv_rx = {slv_rx[46:0], spi_mosi};
        rises = rises + 1;
      end else if (prev_sclk && !spi_sclk) begin
        slv_tx = {slv_tx[46:0], 1'b0};
        spi_miso <= slv_tx[47];
      end
    end
    prev_cs = spi_cs_n;
    prev_sclk = spi_sclk;
  end

  typedef struct {
    int   x;
    int   y;
    logic xi;
    logic xd;
    logic yi;
    logic yd;
  } vec_t;

  vec_t        tbl[14];
  int          vectors = 0;
  int          miscompares = 0;
  logic [27:0] prev_outs = '0;
  logic        prev_rst = 1'b0;

  function automatic logic [27:0] outs_now();
    return {x_accel, y_accel, x_increment, x_decrement, y_increment, y_decrement};
  endfunction

  // Magnitude view of the tilt rule: beyond DB asserts by sign; between DB-HY and DB only
  // a command already pointing the same way as v survives; below DB-HY everything clears.
  function automatic logic [1:0] ref_cmd(input int v, input logic inc, input logic dec);
    int mag;
    mag = (v < 0) ? -v : v;
    if (mag > DB) return (v > 0) ? 2'b10 : 2'b01;
    if (mag >= DB - HY) begin
      if ((v > 0) && inc) return 2'b10;
      if ((v < 0) && dec) return 2'b01;
    end
    return 2'b00;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    if (reset && prev_rst && !sample_valid && (outs_now() !== prev_outs)) begin
      miscompares++;
      $display("FAIL hold: outputs %h became %h without sample_valid", prev_outs, outs_now());
    end
    if ((x_increment && x_decrement) || (y_increment && y_decrement)) begin
      miscompares++;
      $display("FAIL pair: x inc/dec %b%b y inc/dec %b%b, required never 11",
               x_increment, x_decrement, y_increment, y_decrement);
    end
    prev_outs = outs_now();
    prev_rst = reset;
  endtask

  task automatic wait_frame(output logic ok);
    int base;
    base = frames_done;
    ok = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      step();
      if (frames_done != base) begin
        ok = 1'b1;
        return;
      end
    end
  endtask

  task automatic wait_sv(output logic ok);
    ok = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      step();
      if (sample_valid) begin
        ok = 1'b1;
        return;
      end
    end
  endtask

  task automatic check_init_frame(input string tag);
    logic ok;
    wait_frame(ok);
    check({tag, "_frame_seen"}, 64'(ok), 64'd1);
    check({tag, "_mosi"}, 64'(last_mosi), 64'h0A2D02);
    check({tag, "_sclk_rises"}, 64'(last_rises), 64'd24);
    step();
    check({tag, "_done_no_cmds"},
          {init_done, x_increment, x_decrement, y_increment, y_decrement}, 64'b10000);
  endtask

  initial begin
    logic       ok;
    logic       mxi, mxd, myi, myd;
    logic [1:0] xc, yc;
    int         x, y;

    tbl[0]  = '{200, -200, 1'b1, 1'b0, 1'b0, 1'b1};
    tbl[1]  = '{0, 0, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[2]  = '{100, -100, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[3]  = '{101, -101, 1'b1, 1'b0, 1'b0, 1'b1};
    tbl[4]  = '{200, 0, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[5]  = '{90, 0, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[6]  = '{84, 0, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[7]  = '{83, 0, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[8]  = '{300, -85, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[9]  = '{-300, -300, 1'b0, 1'b1, 1'b0, 1'b1};
    tbl[10] = '{-84, 84, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[11] = '{-83, 2047, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[12] = '{-2048, -2048, 1'b0, 1'b1, 1'b0, 1'b1};
    tbl[13] = '{-100, 100, 1'b0, 1'b1, 1'b0, 1'b0};

    slave_x = tbl[0].x;
    slave_y = tbl[0].y;
    repeat (3) step();
    check("reset_state", {spi_cs_n, spi_sclk, spi_mosi, init_done, sample_valid, outs_now()},
          {1'b1, 32'd0});
    reset = 1'b1;
    check_init_frame("init");

    for (int i = 0; i < 14; i++) begin
      if (i > 0) begin
        slave_x = tbl[i].x;
        slave_y = tbl[i].y;
      end
      wait_sv(ok);
      check($sformatf("vec%0d_x%0d_y%0d", i, tbl[i].x, tbl[i].y), {ok, outs_now()},
            {1'b1, 12'(tbl[i].x), 12'(tbl[i].y), tbl[i].xi, tbl[i].xd, tbl[i].yi, tbl[i].yd});
      step();
      check($sformatf("vec%0d_sv_pulse", i), 64'(sample_valid), 64'd0);
      if (i == 1) begin
        check("read_mosi", 64'(last_mosi), {16'h0B0E, 32'h0});
        check("read_sclk_rises", 64'(last_rises), 64'd48);
      end
    end

    mxi = 1'b0; mxd = 1'b1; myi = 1'b0; myd = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 9) < 7) begin
        x = int'($urandom_range(0, 260)) - 130;
        y = int'($urandom_range(0, 260)) - 130;
      end else begin
        x = int'($urandom_range(0, 4095)) - 2048;
        y = int'($urandom_range(0, 4095)) - 2048;
      end
      slave_x = x;
      slave_y = y;
      xc = ref_cmd(x, mxi, mxd);
      yc = ref_cmd(y, myi, myd);
      {mxi, mxd} = xc;
      {myi, myd} = yc;
      wait_sv(ok);
      check($sformatf("rnd%0d_x%0d_y%0d", i, x, y), {ok, outs_now()},
            {1'b1, 12'(x), 12'(y), xc, yc});
      step();
    end

    // Abort a READ frame inside its fourth byte (SCLK rises 25..32).
    for (int n = 0; n < 2000 && !spi_cs_n; n++) step();
    for (int n = 0; n < 2000 && spi_cs_n; n++) step();
    step();
    for (int n = 0; n < 2000 && rises < 27; n++) step();
    check("abort_in_byte4", 64'((rises >= 25) && (rises <= 31)), 64'd1);
    @(posedge clk);
    #3 reset = 1'b0;
    #1;
    check("reset_async", {spi_cs_n, spi_sclk, spi_mosi, init_done, sample_valid, outs_now()},
          {1'b1, 32'd0});
    repeat (3) step();
    check("reset_held", {spi_cs_n, spi_sclk, spi_mosi, init_done, sample_valid, outs_now()},
          {1'b1, 32'd0});
    reset = 1'b1;
    check_init_frame("reinit");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
